// File: rtl/dsp_sample_sequencer.sv
// Sequences buffered ADC samples through a fixed-latency datapath with a
// valid/ready result stage. Optional drop counter: define SEQ_DROP_COUNT_EN.
module dsp_sample_sequencer #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PROC_LAT   = 2
) (
  input  logic              input_clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              proc_start,
  output logic [DATA_W-1:0] proc_in_data,
  input  logic [DATA_W-1:0] proc_out_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              overflow,
  input  logic              clear_overflow,
  output logic [7:0]        drop_count
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned LAT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t              state;
  logic [LAT_W-1:0]    lat_cnt;

  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]    count;

  logic                fifo_empty;
  logic                fifo_full;
  logic                push;
  logic                pop;
  logic                drop;
  logic [DATA_W-1:0]   head;

  // FIFO control: a full FIFO still accepts a word when the same cycle pops
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign pop        = (state == ISSUE);
  assign push       = in_valid && (!fifo_full || pop);
  assign drop       = in_valid && fifo_full && !pop;

  // Head with bypass so HOLD can issue a word arriving in its final cycle
  assign head = fifo_empty ? in_data : mem[rd_ptr];

  assign busy = (state != IDLE) || !fifo_empty;

  always_ff @(posedge input_clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge input_clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge input_clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

`ifdef SEQ_DROP_COUNT_EN
  logic [7:0] drop_cnt;

  always_ff @(posedge input_clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= 8'd0;
    end else if (clear_overflow) begin
      drop_cnt <= drop ? 8'd1 : 8'd0;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign drop_count = drop_cnt;
`else
  assign drop_count = 8'd0;
`endif

  // Sequencer: issue outputs are registered on entry to ISSUE
  always_ff @(posedge input_clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      lat_cnt      <= '0;
      proc_start   <= 1'b0;
      proc_in_data <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
    end else begin
      proc_start <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state        <= ISSUE;
            proc_start   <= 1'b1;
            proc_in_data <= mem[rd_ptr];
          end
        end
        ISSUE: begin
          lat_cnt <= LAT_W'(PROC_LAT);
          if (PROC_LAT == 0) begin
            out_data  <= proc_out_data;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt - LAT_W'(1);
          if (lat_cnt == LAT_W'(1)) begin
            out_data  <= proc_out_data;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (!fifo_empty || push) begin
              state        <= ISSUE;
              proc_start   <= 1'b1;
              proc_in_data <= head;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_sample_sequencer.sv
// Self-checking bench for dsp_sample_sequencer: directed scenarios plus random
// traffic, compared every cycle against a queue/timestamp reference model.
module tb_dsp_sample_sequencer;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PL    = 2;

  logic          input_clk;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          proc_start;
  logic [DW-1:0] proc_in_data;
  logic [DW-1:0] proc_out_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          busy;
  logic          overflow;
  logic          clear_overflow;
  logic [7:0]    drop_count;

  int n_checks = 0;
  int n_fail   = 0;
  longint cyc  = 0;

  dsp_sample_sequencer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .PROC_LAT(PL)) dut (
    .input_clk      (input_clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .proc_start     (proc_start),
    .proc_in_data   (proc_in_data),
    .proc_out_data  (proc_out_data),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .busy           (busy),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .drop_count     (drop_count)
  );

  initial input_clk = 1'b0;
  always #5 input_clk = ~input_clk;

  // Datapath stand-in: adds one, PL cycles of latency
  if (PL == 0) begin : g_dp_comb
    assign proc_out_data = proc_in_data + 16'd1;
  end else begin : g_dp_pipe
    logic [DW-1:0] dp [PL];
    always @(posedge input_clk) begin
      dp[0] <= proc_in_data + 16'd1;
      for (int i = 1; i < PL; i++) dp[i] <= dp[i-1];
    end
    assign proc_out_data = dp[PL-1];
  end

  // Reference model state
  logic [DW-1:0] q[$];
  bit            m_active;
  bit            m_hold;
  longint        m_issue_cyc;
  logic [DW-1:0] m_word;
  logic [DW-1:0] m_pin;
  logic [DW-1:0] m_out;
  bit            m_ovf;
  int            m_drops;

  task automatic model_reset();
    q.delete();
    m_active    = 0;
    m_hold      = 0;
    m_issue_cyc = -1;
    m_word      = '0;
    m_pin       = '0;
    m_out       = '0;
    m_ovf       = 0;
    m_drops     = 0;
  endtask

  task automatic model_update(input logic iv, input logic [DW-1:0] d,
                              input logic rdy, input logic clr);
    bit was_idle     = !m_active;
    bit hold_start   = m_hold;
    bit pre_nonempty = (q.size() != 0);
    bit full         = (q.size() == DEPTH);
    bit issuing      = m_active && (cyc == m_issue_cyc);
    bit dropped;
    if (issuing) m_word = q.pop_front();
    dropped = iv && full && !issuing;
    if (iv && !dropped) q.push_back(d);
    if (m_active && !m_hold && (cyc == m_issue_cyc + PL)) begin
      m_hold = 1;
      m_out  = m_word + 16'd1;
    end
    if (hold_start && rdy) begin
      m_hold   = 0;
      m_active = 0;
      if (q.size() != 0) begin
        m_active    = 1;
        m_issue_cyc = cyc + 1;
        m_pin       = q[0];
      end
    end else if (was_idle && pre_nonempty) begin
      m_active    = 1;
      m_issue_cyc = cyc + 1;
      m_pin       = q[0];
    end
    if (dropped) m_ovf = 1;
    else if (clr) m_ovf = 0;
`ifdef SEQ_DROP_COUNT_EN
    if (clr) m_drops = dropped ? 1 : 0;
    else if (dropped && m_drops < 255) m_drops++;
`else
    m_drops = 0;
`endif
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("proc_start",   32'(proc_start),   32'(m_active && (m_issue_cyc == cyc)));
    chk("proc_in_data", 32'(proc_in_data), 32'(m_pin));
    chk("out_valid",    32'(out_valid),    32'(m_hold));
    chk("out_data",     32'(out_data),     32'(m_out));
    chk("busy",         32'(busy),         32'(m_active || (q.size() != 0)));
    chk("overflow",     32'(overflow),     32'(m_ovf));
    chk("drop_count",   32'(drop_count),   32'(m_drops));
  endtask

  // One clock cycle: drive, check at negedge, advance model, move past posedge
  task automatic step(input logic iv, input logic [DW-1:0] d,
                      input logic rdy, input logic clr);
    in_valid       = iv;
    in_data        = d;
    out_ready      = rdy;
    clear_overflow = clr;
    @(negedge input_clk);
    check_all();
    model_update(iv, d, rdy, clr);
    @(posedge input_clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, rdy, 1'b0);
  endtask

  initial begin
    rst            = 1'b1;
    in_valid       = 1'b0;
    in_data        = '0;
    out_ready      = 1'b0;
    clear_overflow = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge input_clk); #1;
    @(posedge input_clk); #1;
    rst = 1'b0;

    // Single sample with consumer always ready
    step(1'b1, 16'h1234, 1'b1, 1'b0);
    idle(10, 1'b1);

    // Back-pressure: result held while out_ready stays low
    step(1'b1, 16'hBEEF, 1'b0, 1'b0);
    idle(16, 1'b0);
    idle(6, 1'b1);

    // Overflow: six back-to-back words, consumer stalled
    for (int i = 1; i <= 6; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    idle(4, 1'b0);
    idle(30, 1'b1);

    // Full FIFO push coinciding with the ISSUE pop
    step(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 16'h0A00 + 16'(i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 16'h0AFF, 1'b0, 1'b0);
    idle(30, 1'b1);

    // Clear and drop in the same cycle
    for (int i = 0; i < 6; i++) step(1'b1, 16'h0B00 + 16'(i), 1'b0, 1'b0);
    step(1'b1, 16'h0BEE, 1'b0, 1'b1);
    idle(2, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    idle(30, 1'b1);

    // Asynchronous reset while WAIT with three words queued
    for (int i = 0; i < 4; i++) step(1'b1, 16'h0C00 + 16'(i), 1'b1, 1'b0);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge input_clk); #1;
    rst = 1'b0;
    cyc++;
    idle(12, 1'b1);
    step(1'b1, 16'h0D01, 1'b1, 1'b0);
    idle(8, 1'b1);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 9) < 6),
           1'($urandom_range(0, 19) == 0));
    end
    idle(20, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
